cache_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one cache controller between up to NUM_REQ requesters (e.g. instruction-fetch and data ports). It accepts requests, latches the winning requester's operands, issues a single-cycle start to the cache controller, waits for its `ready`, and returns read data with a per-requester completion pulse. It sits between the requester ports and the cache controller's opcode/address/data/ready interface.

---
 rtl/cache_port_arbiter.sv | 99 +++++++++
 tb/tb_cache_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of one cache controller; define CACHE_ARB_TIMEOUT_EN to add a WAIT watchdog
module cache_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int WORD_SIZE = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_b,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   req_opcode,
  input  logic [NUM_REQ*ADDRESS_WORD_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   done,
  output logic [WORD_SIZE-1:0]                 rdata,
  output logic                                 err,
  output logic                                 busy,
  output logic                                 cache_start,
  output logic                                 cache_opcode,
  output logic [ADDRESS_WORD_SIZE-1:0]         cache_addr,
  output logic [WORD_SIZE-1:0]                 cache_wdata,
  input  logic                                 cache_ready,
  input  logic [WORD_SIZE-1:0]                 cache_rdata
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] last, idx, win;
  logic timeout;
  logic [ADDRESS_WORD_SIZE-1:0] addr_a [NUM_REQ];
  logic [WORD_SIZE-1:0] wdata_a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign addr_a[i] = req_addr[i*ADDRESS_WORD_SIZE +: ADDRESS_WORD_SIZE];
    assign wdata_a[i] = req_wdata[i*WORD_SIZE +: WORD_SIZE];
  end
  function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] l);
    logic [IW-1:0] c;
    pick = l;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = IW'((int'(l) + k) % NUM_REQ);
      if (r[c]) pick = c;
    end
  endfunction
  assign win = pick(req, last);
  always_comb begin
    state_n = (state == IDLE)  ? ((|req) ? GRANT : IDLE) :
              (state == GRANT) ? WAIT :
              (state == WAIT)  ? ((cache_ready || timeout) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= IDLE;
      last <= IW'(NUM_REQ - 1);
      idx <= '0;
      cache_opcode <= 1'b0;
      cache_addr <= '0;
      cache_wdata <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) begin
        idx <= win;
        cache_opcode <= req_opcode[win];
        cache_addr <= addr_a[win];
        cache_wdata <= wdata_a[win];
      end
      if (state == WAIT && cache_ready) rdata <= cache_rdata;
      else if (state == WAIT && timeout) rdata <= '0;
      if (state == DONE) last <= idx;
    end
  end
  assign gnt = (state == GRANT) ? NUM_REQ'(1) << idx : '0;
  assign done = (state == DONE) ? NUM_REQ'(1) << idx : '0;
  assign cache_start = state == GRANT;
  assign busy = state != IDLE;
`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      err_q <= timeout && !cache_ready;
    end
  end
  // cnt counts completed WAIT cycles, so the limit is hit on the TIMEOUT_CYCLES-th WAIT cycle
  assign timeout = (state == WAIT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: table vectors, hand sequences and randomized transactions against a round-robin model
module tb_cache_port_arbiter;
  localparam int N = 2, AW = 32, DW = 8;
  logic clk = 1'b0, rst_b = 1'b1;
  logic [N-1:0] req = '0, req_opcode = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] gnt, done;
  logic [DW-1:0] rdata, cache_wdata, cache_rdata = '0;
  logic err, busy, cache_start, cache_opcode, cache_ready = 1'b0;
  logic [AW-1:0] cache_addr;
  int n_chk = 0, n_fail = 0, m_last = N - 1;

  cache_port_arbiter #(.NUM_REQ(N), .ADDRESS_WORD_SIZE(AW), .WORD_SIZE(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_opcode(req_opcode), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .cache_start(cache_start), .cache_opcode(cache_opcode), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_ready(cache_ready), .cache_rdata(cache_rdata));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] r, op;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1, rd;
    int d;
    bit hold;
    int exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, gnt, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rdata"}, rdata, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_start"}, cache_start, 0);
    chk({nm, "_op"}, cache_opcode, 0);
    chk({nm, "_addr"}, cache_addr, 0);
    chk({nm, "_wdata"}, cache_wdata, 0);
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic do_txn(input vec_t v);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic eo;
    ea = v.exp == 1 ? v.a1 : v.a0;
    ew = v.exp == 1 ? v.w1 : v.w0;
    eo = v.op[v.exp];
    req = v.r; req_opcode = v.op; req_addr = {v.a1, v.a0}; req_wdata = {v.w1, v.w0};
    for (int c = 0; c < 8 && gnt == 0; c++) step();
    chk("gnt", gnt, 1 << v.exp);
    chk("start", cache_start, 1);
    chk("grant_addr", cache_addr, ea);
    chk("grant_op", cache_opcode, eo);
    chk("grant_wdata", cache_wdata, ew);
    if (!v.hold) begin
      req = '0; req_addr = ~req_addr; req_wdata = ~req_wdata; req_opcode = ~req_opcode;
    end
    cache_ready = v.d > 1;
    for (int i = 1; i < v.d; i++) begin
      step();
      cache_ready = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_gnt", gnt, 0);
      chk("wait_start", cache_start, 0);
      chk("wait_done", done, 0);
      chk("wait_addr", cache_addr, ea);
      chk("wait_wdata", cache_wdata, ew);
    end
    step();
    cache_ready = 1'b1; cache_rdata = v.rd;
    step();
    cache_ready = 1'b0; cache_rdata = ~v.rd;
    chk("done", done, 1 << v.exp);
    chk("rdata", rdata, v.rd);
    chk("done_err", err, 0);
    chk("done_busy", busy, 1);
    step();
    chk("idle_done", done, 0);
    chk("idle_rdata", rdata, v.rd);
    chk("idle_busy", busy, 0);
    m_last = v.exp;
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{2'b01, 2'b00, 32'h10, 32'h0, 8'h11, 8'h22, 8'hA5, 3, 1'b0, 0};
    tbl[1] = '{2'b11, 2'b11, 32'h100, 32'h200, 8'h31, 8'h32, 8'h01, 1, 1'b1, 1};
    tbl[2] = '{2'b11, 2'b11, 32'h104, 32'h204, 8'h41, 8'h42, 8'h02, 2, 1'b1, 0};
    tbl[3] = '{2'b11, 2'b11, 32'h108, 32'h208, 8'h51, 8'h52, 8'h03, 1, 1'b1, 1};
    tbl[4] = '{2'b11, 2'b11, 32'h10C, 32'h20C, 8'h61, 8'h62, 8'h04, 4, 1'b1, 0};
    tbl[5] = '{2'b10, 2'b00, 32'hDEAD, 32'h300, 8'h71, 8'h72, 8'h5C, 3, 1'b0, 1};
    tbl[6] = '{2'b11, 2'b01, 32'h400, 32'h500, 8'h81, 8'h82, 8'hC3, 2, 1'b0, 0};
    tbl[7] = '{2'b11, 2'b10, 32'h600, 32'h700, 8'h91, 8'h92, 8'h3C, 1, 1'b0, 1};
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    chk_zero("reset");
    for (int t = 0; t < 8; t++) do_txn(tbl[t]);
    req = '0; cache_ready = 1'b1;
    step();
    cache_ready = 1'b0;
    chk("idle_ready_busy", busy, 0);
    chk("idle_ready_done", done, 0);
    step();
    chk("idle_ready_done2", done, 0);
    req = 2'b01; req_opcode = 2'b01; req_addr = {32'h0, 32'hABCD}; req_wdata = 16'h1234;
    step();
    chk("rstw_gnt", gnt, 2'b01);
    req = '0;
    step();
    chk("rstw_busy", busy, 1);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk_zero("rst_wait");
    step();
    chk("rst_wait_done", done, 0);
    chk("rst_wait_busy", busy, 0);
    m_last = N - 1;
    do_txn('{2'b10, 2'b00, 32'h0, 32'h800, 8'h00, 8'h00, 8'h77, 2, 1'b0, 1});
    for (int t = 0; t < 25; t++) begin
      rv.r = N'($urandom_range(1, 3));
      rv.op = N'($urandom);
      rv.a0 = $urandom; rv.a1 = $urandom;
      rv.w0 = DW'($urandom); rv.w1 = DW'($urandom);
      rv.rd = DW'($urandom_range(1, 255));
      rv.d = $urandom_range(1, 4);
      rv.hold = 1'($urandom_range(0, 1));
      rv.exp = rr_winner(rv.r, m_last);
      do_txn(rv);
    end
    req = 2'b01; req_opcode = '0; req_addr = {32'h0, 32'h44}; req_wdata = '0;
    for (int c = 0; c < 8 && gnt == 0; c++) step();
    chk("to_gnt", gnt, 2'b01);
    req = '0;
`ifdef CACHE_ARB_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("to_wait_done", done, 0);
      chk("to_wait_busy", busy, 1);
    end
    step();
    chk("to_done", done, 2'b01);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    step();
    chk("to_err_clear", err, 0);
    chk("to_idle", busy, 0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("nto_busy", busy, 1);
      chk("nto_err", err, 0);
      chk("nto_done", done, 0);
    end
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("nto_reset_busy", busy, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
